// File: rtl/uart_image_loader.sv
// UART-to-RAM image loader: receives DEPTH words on rx into a dual-port RAM
// with a registered read port, and announces ready/done bytes on tx.
module uart_image_loader #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter logic [7:0]  READY_BYTE = 8'h33,
  parameter logic [7:0]  DONE_BYTE  = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 restart,
  input  logic [ADDR_W-1:0]    addr_b,
  output logic [DATA_BITS-1:0] data_b,
  output logic                 tx,
  output logic [ADDR_W:0]      wr_count,
  output logic                 load_done,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W   = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W   = $clog2(DATA_BITS);
  localparam int unsigned WC_W    = ADDR_W + 1;
  localparam int unsigned WORDS   = 1 << ADDR_W;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0]     HALF     = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0]     FULL     = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [WC_W-1:0]      DEPTH_C  = WC_W'(DEPTH);
  localparam logic [DATA_BITS-1:0] READY_W  = DATA_BITS'(READY_BYTE);
  localparam logic [DATA_BITS-1:0] DONE_W   = DATA_BITS'(DONE_BYTE);
  localparam logic                 ODD      = (PARITY == 2);
  localparam logic                 HAS_PAR  = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

  // Oversample tick generator
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Two-flop synchroniser, idle high
  logic rx_meta, rx_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------- RX ----------------
  uart_state_e          rx_state, rx_next;
  logic [CNT_W-1:0]     rx_cnt;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par;
  logic                 rx_half_c, rx_full_c;
  logic                 word_ok_c, frame_bad_c, parity_bad_c;

  assign rx_half_c = tick && (rx_cnt == HALF);
  assign rx_full_c = tick && (rx_cnt == FULL);

  always_ff @(posedge clk) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      S_IDLE:   if (!rx_s) rx_next = S_START;
      S_START:  if (rx_half_c) rx_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (rx_full_c && rx_idx == LAST_IDX) rx_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (rx_full_c) rx_next = S_STOP;
      S_STOP:   if (rx_full_c) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
  end

  // Stop-bit verdict: framing beats parity, only clean words are accepted
  always_comb begin
    word_ok_c    = 1'b0;
    frame_bad_c  = 1'b0;
    parity_bad_c = 1'b0;
    if (rx_state == S_STOP && rx_full_c) begin
      if (!rx_s)                                    frame_bad_c  = 1'b1;
      else if (HAS_PAR && (rx_par != (^rx_shift ^ ODD))) parity_bad_c = 1'b1;
      else                                          word_ok_c    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (rx_next != S_IDLE);
      if (rx_state == S_IDLE || (rx_state == S_START && rx_half_c) || rx_full_c) rx_cnt <= '0;
      else if (tick) rx_cnt <= rx_cnt + 1'b1;
      if (rx_state != S_DATA) rx_idx <= '0;
      else if (rx_full_c)     rx_idx <= rx_idx + 1'b1;
      if (rx_state == S_DATA && rx_full_c)   rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
      if (rx_state == S_PARITY && rx_full_c) rx_par   <= rx_s;
    end
  end

  // ---------------- image bookkeeping ----------------
  logic [WC_W-1:0] wr_base_c, wr_next_c;
  logic            do_write_c, done_set_c;

  // restart rebases the write pointer before the incoming word is placed
  assign wr_base_c  = restart ? '0 : wr_count;
  assign do_write_c = word_ok_c && (wr_base_c < DEPTH_C);
  assign wr_next_c  = do_write_c ? wr_base_c + 1'b1 : wr_base_c;
  assign done_set_c = do_write_c && (wr_next_c == DEPTH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count   <= '0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      wr_count   <= wr_next_c;
      load_done  <= (wr_next_c == DEPTH_C);
      frame_err  <= !restart && (frame_err || frame_bad_c);
      parity_err <= !restart && (parity_err || parity_bad_c);
    end
  end

  // RAM array has no reset so the image survives rst
  logic [DATA_BITS-1:0] ram [WORDS];
  always_ff @(posedge clk) begin
    if (!rst && do_write_c) ram[wr_base_c[ADDR_W-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) data_b <= '0;
    else     data_b <= ram[addr_b];
  end

  // ---------------- TX ----------------
  uart_state_e          tx_state, tx_next;
  logic [CNT_W-1:0]     tx_cnt;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shift, tx_word_c;
  logic                 tx_par, tx_full_c, tx_take_c, tx_line_c;
  logic                 ready_pend, done_pend;

  assign tx_full_c = tick && (tx_cnt == FULL);
  assign tx_take_c = (tx_state == S_IDLE) && (ready_pend || done_pend);
  assign tx_word_c = ready_pend ? READY_W : DONE_W;

  always_ff @(posedge clk) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      S_IDLE:   if (ready_pend || done_pend) tx_next = S_START;
      S_START:  if (tx_full_c) tx_next = S_DATA;
      S_DATA:   if (tx_full_c && tx_idx == LAST_IDX) tx_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (tx_full_c) tx_next = S_STOP;
      S_STOP:   if (tx_full_c) tx_next = S_IDLE;
      default:  tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_line_c = 1'b1;
    unique case (tx_state)
      S_START:  tx_line_c = 1'b0;
      S_DATA:   tx_line_c = tx_shift[0];
      S_PARITY: tx_line_c = tx_par;
      default:  tx_line_c = 1'b1;
    endcase
  end

  // READY takes priority; restart re-arms READY and drops a pending DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      tx         <= 1'b1;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      ready_pend <= 1'b1;
      done_pend  <= 1'b0;
    end else begin
      tx <= tx_line_c;
      if (tx_state == S_IDLE || tx_full_c) tx_cnt <= '0;
      else if (tick) tx_cnt <= tx_cnt + 1'b1;
      if (tx_state != S_DATA) tx_idx <= '0;
      else if (tx_full_c)     tx_idx <= tx_idx + 1'b1;
      if (tx_take_c) begin
        tx_shift <= tx_word_c;
        tx_par   <= ^tx_word_c ^ ODD;
      end else if (tx_state == S_DATA && tx_full_c) begin
        tx_shift <= tx_shift >> 1;
      end
      ready_pend <= restart || (ready_pend && !(tx_take_c && ready_pend));
      done_pend  <= !restart && (done_set_c || (done_pend && !(tx_take_c && !ready_pend)));
    end
  end

endmodule

// File: doc/uart_image_loader.md
Name: uart_image_loader

Overview:
- Parametrised UART-to-BRAM image loader: receives a fixed-size image byte stream on `rx` and writes it sequentially into an internal dual-port RAM.
- The RAM is read back through a synchronous read port.
- Announces readiness (READY_BYTE) and completion (DONE_BYTE) on `tx`; flags framing and parity errors.
- Successor to the fixed 115200/8N1/1K loader: generalised baud, word width, parity mode and depth, plus completion signalling and re-arm.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, ticks per bit (even, ≥8).
- DATA_BITS, 8, bits per UART word and RAM word width (5..9).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- DEPTH, 1024, image size in words.
- ADDR_W, 10, ceil(log2(DEPTH)).
- READY_BYTE, 8'h33, sent after reset and after restart (low DATA_BITS bits used).
- DONE_BYTE, 8'hAA, sent once when image complete.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- restart  in  1  one-cycle pulse: clear image state and re-send READY_BYTE.
- addr_b  in  ADDR_W  RAM read address.
- data_b  out  DATA_BITS  RAM read data, registered.
- tx  out  1  serial output, idle high.
- wr_count  out  ADDR_W+1  words stored so far.
- load_done  out  1  high when wr_count == DEPTH.
- busy  out  1  RX frame in progress.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.

Behaviour:
- **Reset (rst high at clk edge):**
  - Outputs: tx=1, data_b=0, wr_count=0, load_done=0, busy=0, frame_err=0, parity_err=0.
  - RX and TX FSMs go to IDLE and the tick counter clears.
  - RAM contents are preserved.
  - Reset mid-frame aborts the frame; tx=1 from the next cycle.
  - After rst deasserts, TX transmits READY_BYTE once.
- **Tick generator:**
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated, minimum 1.
  - Free-running counter emits a one-clk `tick` every DIV clks.
- **RX synchroniser:** 2-FF synchroniser on rx; all RX logic uses the synchronised signal.
- **RX FSM (IDLE, START, DATA, PARITY, STOP), counting ticks:**
  - IDLE → START on synchronised rx = 0.
  - START: at tick OVERSAMPLE/2-1, re-sample. If rx = 1, treat as a glitch and return to IDLE with no error. Otherwise go to DATA.
  - DATA: sample every OVERSAMPLE ticks (mid-bit), LSB first, DATA_BITS bits. Then go to PARITY if PARITY≠0, else STOP.
  - PARITY: sample and compare.
  - STOP: sample after OVERSAMPLE ticks.
    - If stop = 0: set frame_err and discard the word.
    - Else if parity mismatch: set parity_err and discard the word.
    - Else: the word is valid.
  - STOP → IDLE immediately after sampling, so back-to-back frames are accepted.
  - busy = (state ≠ IDLE).
- **RAM write:**
  - A valid word with wr_count < DEPTH is written at address wr_count[ADDR_W-1:0] in the same clk as the STOP sample; wr_count increments.
  - When wr_count reaches DEPTH, load_done=1 and DONE_BYTE is queued on TX.
  - Words arriving while load_done=1 are received and error-checked but not written. wr_count does not change and does not wrap.
- **RAM read:** data_b = RAM[addr_b] one clk after addr_b is presented. Read and write to the same address in the same clk returns old data.
- **TX FSM (IDLE, START, DATA, PARITY, STOP):**
  - OVERSAMPLE ticks per bit, LSB first.
  - Parity bit is included if PARITY≠0.
  - One stop bit.
  - One pending-request flag each for READY and DONE.
  - From IDLE, READY has priority over DONE.
  - A request raised while TX is busy is held and sent after the current frame completes. Duplicate requests collapse to one.
- **restart pulse:**
  - Clears wr_count, load_done, frame_err and parity_err.
  - Cancels a pending DONE.
  - Queues READY.
  - Does not abort an RX frame in progress. That frame's valid word is written at address 0.
- **Simultaneous events:**
  - restart and a valid word in the same clk: restart wins; the word is written at address 0 and wr_count=1.
  - rst overrides everything.

Test Plan:
- Bench uses CLK_FREQ=1843200, BAUD=115200, OVERSAMPLE=16 (DIV=1), DEPTH=4, ADDR_W=2.
- Release rst → tx frame decodes 0x33 (8N1); no other tx activity; wr_count=0, load_done=0.
- Send 0x11,0x22,0x33,0x44 → wr_count 1..4. load_done rises in the clk of the 4th STOP sample. tx then sends 0xAA. Reading addr_b=0..3 gives 0x11,0x22,0x33,0x44, each one clk after the address.
- Send 0x55 after load_done → RAM unchanged, wr_count=4, no second 0xAA.
- Frame with stop bit forced 0 → frame_err=1, word not written; the next valid frame is stored normally.
- PARITY=1: send 0x07 with parity bit 0 → parity_err=1, discarded. Send 0x07 with parity bit 1 → stored.
- 0.25-bit low glitch on rx → no write, no error, busy returns to 0. Then restart pulse during 0xAA transmission → 0xAA completes, then 0x33 is sent, with wr_count=0 and both error flags cleared.
